serv_rf_stream_bridge: RTL

//  Bridges the bit-serial register-file request interface driven by serv_state (o_rf_rreq/o_rf_wreq -> i_rf_ready)
//  to a single-port synchronous RAM of RAM_W-bit words. Prefetches rs1/rs2, streams them LSB-first at 1 bit/cycle,
//  and collects the bit-serial rd result into RAM_W-bit chunks written back behind the stream.

---
 rtl/serv_rf_stream_bridge.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/serv_rf_stream_bridge.sv
// rtl/serv_rf_stream_bridge.sv - bit-serial register file stream to RAM_W-bit synchronous RAM bridge
// Prefetches rs1/rs2 chunks one window ahead and writes rd chunks one window behind.
module serv_rf_stream_bridge #(
  parameter int RAM_W = 8,
  localparam int AW = 5 + $clog2(32 / RAM_W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rreq,
  input  logic             i_wreq,
  output logic             o_ready,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  input  logic [4:0]       i_rd_addr,
  input  logic             i_wen,
  input  logic             i_wdata,
  output logic             o_rs1,
  output logic             o_rs2,
  output logic [AW-1:0]    o_ram_addr,
  output logic             o_ram_ren,
  output logic             o_ram_wen,
  output logic [RAM_W-1:0] o_ram_wdata,
  input  logic [RAM_W-1:0] i_ram_rdata
);
  localparam int NW = 32 / RAM_W;
  localparam int CW = $clog2(NW);
  localparam int LW = $clog2(RAM_W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] TAIL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic             wen_q, wen_d;
  logic [1:0]       last_rd_q, last_rd_d;
  logic [RAM_W-1:0] pre1_q, pre1_d, pre2_q, pre2_d;
  logic [RAM_W-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [RAM_W-1:0] wsh_q, wsh_d, wbuf_q, wbuf_d;

  logic             req, accept, last_pos, rd_sel1;
  logic             ram_ren, ram_wen;
  logic [4:0]       ram_reg;
  logic [5:0]       ram_chunk, win;
  logic [LW-1:0]    pos;
  logic [10:0]      addr_full;

  always_comb begin
    req      = i_rreq | i_wreq;
    pos      = cnt_q[LW-1:0];
    win      = cnt_q >> LW;
    last_pos = (pos == LW'(RAM_W - 1));
    accept   = ((state_q == IDLE) && req) ||
               ((state_q == TAIL) && (cnt_q == 6'd34) && (pend_q || req));

    // Slot schedule: reads of the next chunk lead each window, write-back of the previous chunk follows.
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_reg   = 5'd0;
    ram_chunk = 6'd0;
    rd_sel1   = 1'b0;
    if (state_q == PRE) begin
      if (cnt_q == 6'd0) begin
        ram_ren = 1'b1;
        ram_reg = rs1_q;
        rd_sel1 = 1'b1;
      end else if (cnt_q == 6'd1) begin
        ram_ren = 1'b1;
        ram_reg = rs2_q;
      end
    end else if ((state_q == RUN) && (win < 6'(NW - 1))) begin
      if (pos == LW'(0)) begin
        ram_ren   = 1'b1;
        ram_reg   = rs1_q;
        ram_chunk = win + 6'd1;
        rd_sel1   = 1'b1;
      end else if (pos == LW'(1)) begin
        ram_ren   = 1'b1;
        ram_reg   = rs2_q;
        ram_chunk = win + 6'd1;
      end
    end
    if (((state_q == RUN) || (state_q == TAIL)) && (pos == LW'(2)) && (win != 6'd0) &&
        wen_q && (rd_q != 5'd0)) begin
      ram_wen   = 1'b1;
      ram_reg   = rd_q;
      ram_chunk = win - 6'd1;
    end
    addr_full = ({6'd0, ram_reg} << CW) | {5'd0, ram_chunk};

    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    wsh_d     = wsh_q;
    wbuf_d    = wbuf_q;
    last_rd_d = {ram_ren & ~rd_sel1, ram_ren & rd_sel1};
    pre1_d    = last_rd_q[0] ? i_ram_rdata : pre1_q;
    pre2_d    = last_rd_q[1] ? i_ram_rdata : pre2_q;

    case (state_q)
      PRE: begin
        if (cnt_q == 6'd2) begin
          // rs2 chunk 0 is still on the RAM bus this cycle, so take it directly.
          state_d = RUN;
          cnt_d   = 6'd0;
          sh1_d   = pre1_q;
          sh2_d   = i_ram_rdata;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      RUN: begin
        sh1_d = sh1_q >> 1;
        sh2_d = sh2_q >> 1;
        wsh_d = {i_wdata, wsh_q[RAM_W-1:1]};
        if (cnt_q == 6'd0) wen_d = i_wen;
        if (last_pos) begin
          wbuf_d = wsh_d;
          if (cnt_q != 6'd31) begin
            sh1_d = pre1_q;
            sh2_d = pre2_q;
          end
        end
        if (cnt_q == 6'd31) state_d = TAIL;
        cnt_d = cnt_q + 6'd1;
      end
      TAIL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd34) state_d = IDLE;
      end
      default: ;
    endcase

    if (req && (state_q != IDLE)) pend_d = 1'b1;
    if (accept) begin
      state_d = PRE;
      cnt_d   = 6'd0;
      pend_d  = 1'b0;
      rs1_d   = i_rs1_addr;
      rs2_d   = i_rs2_addr;
      rd_d    = i_rd_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      pend_q    <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      wen_q     <= 1'b0;
      last_rd_q <= 2'd0;
      pre1_q    <= '0;
      pre2_q    <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      wsh_q     <= '0;
      wbuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      last_rd_q <= last_rd_d;
      pre1_q    <= pre1_d;
      pre2_q    <= pre2_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      wsh_q     <= wsh_d;
      wbuf_q    <= wbuf_d;
    end
  end

  assign o_ready     = (state_q == PRE) && (cnt_q == 6'd2);
  assign o_rs1       = (state_q == RUN) && (rs1_q != 5'd0) && sh1_q[0];
  assign o_rs2       = (state_q == RUN) && (rs2_q != 5'd0) && sh2_q[0];
  assign o_ram_ren   = ram_ren;
  assign o_ram_wen   = ram_wen;
  assign o_ram_addr  = addr_full[AW-1:0];
  assign o_ram_wdata = wbuf_q;
endmodule
